key_pulse_gen: RTL and testbench
================================

# key_pulse_gen

Upstream front end for the lab 2-bit counter. It turns a raw, bouncing push-button into clean single-cycle count-enable pulses. The raw key is synchronised and debounced, and exactly one pulse is emitted per accepted press, with optional auto-repeat while the key is held. `en_pulse` wires straight to the counter's `en`, so each pulse advances the count by exactly one.

## Interface
- `DEB_CYCLES`, default 1000000: number of consecutive stable synchronised samples needed to accept a press or a release (20 ms at 50 MHz).
- `REP_DELAY`, default 25000000: cycles from the press pulse to the first repeat pulse.
- `REP_PERIOD`, default 10000000: cycles between later repeat pulses.
- `CNT_W`, default 25: width of the debounce and repeat counters.
- Constraints: DEB_CYCLES ≥ 1, REP_DELAY ≥ 2, REP_PERIOD ≥ 2, and every count value < 2^CNT_W.

Ports:
- `clk`, in, 1: single clock. Everything is rising-edge.
- `r`, in, 1: reset, asynchronous, active-high.
- `key`, in, 1: raw button, asynchronous to `clk`, 1 = pressed.
- `rep_en`, in, 1: auto-repeat enable. Sampled every cycle.
- `en_pulse`, out, 1: registered, one cycle wide. Goes to the counter's `en`.
- `key_level`, out, 1: registered debounced key state.

## Operation
- **Synchroniser.** Two flops, `key` → s1 → s2. Only s2 (`key_s`) is used downstream.
- **States.**
  - IDLE: key_level = 0.
  - ARM_P: counting a press.
  - HELD: key_level = 1.
  - ARM_R: counting a release. key_level stays 1.
- **IDLE → ARM_P** when key_s = 1. The debounce counter loads 1.
- **ARM_P.**
  - key_s = 0: return to IDLE and clear the counter.
  - key_s = 1 and count = DEB_CYCLES: go to HELD, en_pulse = 1, clear the repeat counter. The count includes the sample that caused entry.
  - DEB_CYCLES = 1 goes IDLE → HELD directly.
- **HELD.**
  - key_s = 0: go to ARM_R, debounce counter = 1.
  - rep_en = 1: the repeat counter increments. First repeat pulse when it reaches REP_DELAY, later pulses every REP_PERIOD.
  - rep_en = 0: the repeat counter is held at 0 and no repeats occur. When rep_en is reasserted, timing restarts from 0 toward REP_DELAY.
- **ARM_R.**
  - key_s = 1: back to HELD. The repeat counter resumes from its frozen value.
  - key_s = 0 and count = DEB_CYCLES: go to IDLE, key_level = 0, no pulse.
  - No repeat pulses are issued while in ARM_R.
- **Pulse width.** en_pulse is never high on two consecutive cycles.
- **Release.** A release never emits a pulse.
- **Counter saturation.** Counters never wrap. Every state transition clears or reloads them.

## Timing
- **Reset.** While r = 1: state = IDLE, s1 = s2 = 0, all counters = 0, en_pulse = 0, key_level = 0. This applies immediately, with no clock needed.
- **Reset mid-hold.** After r falls with the key still pressed, the full debounce is redone and a fresh press pulse follows.
- **Press latency.** Let k be the first edge that samples `key` = 1.
  - key_s is high after edge k+1.
  - en_pulse and key_level rise at edge k+1+DEB_CYCLES, provided key stays high.
  - en_pulse falls at the next edge.
- **Repeat timing.** Let P be the press-pulse edge, with HELD and rep_en = 1 throughout. Repeats occur at edges P+REP_DELAY, then P+REP_DELAY+n·REP_PERIOD.
- **Release latency.** Let j be the first edge that samples `key` = 0 in HELD. key_level falls at edge j+1+DEB_CYCLES.
- **Bounce filtering.** A low glitch shorter than DEB_CYCLES samples while held is invisible, apart from repeats being delayed by the glitch length.
- **Simultaneous events.** If a repeat deadline coincides with key_s = 0, the transition to ARM_R wins and no pulse is issued.

## Test plan
All scenarios use DEB_CYCLES = 4, REP_DELAY = 10, REP_PERIOD = 3, CNT_W = 8.
1. **Reset.** Assert r mid-cycle, key = 1 → en_pulse = 0 and key_level = 0 immediately. Release r → first pulse at the 6th edge after release.
2. **Clean press, rep_en = 0.** key rises before edge 10 and is held for 40 cycles → exactly one en_pulse, high between edges 15 and 16. key_level = 1 from edge 15. After key falls, key_level = 0 five edges later.
3. **Bounce.** key pattern 1,1,0,1,1,0 then steady 1 from edge 20 → no pulse during the bounce. Single pulse at edge 25.
4. **Auto-repeat.** rep_en = 1, key held from edge 10 → pulses at edges 15, 25, 28, 31, 34. Deassert rep_en at edge 35 → no further pulses.
5. **Release glitch.** While held, key = 0 for 2 cycles → key_level stays 1, no extra pulse, repeat schedule shifted by 2 cycles.
6. **Chain check.** Drive the counter from en_pulse, with 5 separate clean presses → counter output q1q0 = 01 (wraps through 3 → 0 and on to 1).

Source files
------------

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw key and repeat-enable in, count-enable pulse and debounced level out
// Signals: key (raw button, 1 = pressed), rep_en (auto-repeat enable),
//          en_pulse (one-cycle count enable), key_level (debounced key state).
// Modports: master drives key/rep_en, slave (the pulse generator) drives en_pulse/key_level.
interface key_pulse_gen_if;
  logic key;
  logic rep_en;
  logic en_pulse;
  logic key_level;
  modport master (output key, rep_en, input en_pulse, key_level);
  modport slave (input key, rep_en, output en_pulse, key_level);
endinterface

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: synchronise and debounce a push-button into single-cycle count-enable pulses
// Ports: clk (rising edge), r (asynchronous active-high reset),
//        kp (slave): key, rep_en in; en_pulse, key_level out (both registered).
module key_pulse_gen #(
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 10000000,
  parameter int CNT_W      = 25
) (
  input logic            clk,
  input logic            r,
  key_pulse_gen_if.slave kp
);
  typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} state_t;
  state_t           state_q;
  logic             s1_q, s2_q, rep_first_q, en_pulse_q, key_level_q;
  logic [CNT_W-1:0] deb_q, rep_q, deb_inc, rep_inc;
  logic             deb_done, rep_hit;
  // deb_q is zero in the stable states, so deb_inc already counts the sample being taken now
  assign deb_inc  = deb_q + CNT_W'(1);
  assign deb_done = deb_inc >= CNT_W'(DEB_CYCLES);
  assign rep_inc  = rep_q + CNT_W'(1);
  // rep_first_q selects the period once the first repeat has been issued
  assign rep_hit  = rep_inc == (rep_first_q ? CNT_W'(REP_PERIOD) : CNT_W'(REP_DELAY));
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      deb_q       <= '0;
      rep_q       <= '0;
      rep_first_q <= 1'b0;
      en_pulse_q  <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      s1_q       <= kp.key;
      s2_q       <= s1_q;
      en_pulse_q <= 1'b0;
      case (state_q)
        IDLE, ARM_P: begin
          if (!s2_q) begin
            state_q <= IDLE;
            deb_q   <= '0;
          end else if (deb_done) begin
            state_q     <= HELD;
            deb_q       <= '0;
            rep_q       <= '0;
            rep_first_q <= 1'b0;
            en_pulse_q  <= 1'b1;
            key_level_q <= 1'b1;
          end else begin
            state_q <= ARM_P;
            deb_q   <= deb_inc;
          end
        end
        HELD, ARM_R: begin
          if (!s2_q) begin
            // a low sample always wins over a repeat deadline; rep_q stays frozen
            if (deb_done) begin
              state_q     <= IDLE;
              deb_q       <= '0;
              rep_q       <= '0;
              rep_first_q <= 1'b0;
              key_level_q <= 1'b0;
            end else begin
              state_q <= ARM_R;
              deb_q   <= deb_inc;
            end
          end else begin
            // the edge returning from ARM_R counts toward the repeat deadline,
            // so a glitch delays repeats by exactly its own length
            state_q <= HELD;
            deb_q   <= '0;
            if (!kp.rep_en) begin
              rep_q       <= '0;
              rep_first_q <= 1'b0;
            end else if (rep_hit) begin
              rep_q       <= '0;
              rep_first_q <= 1'b1;
              en_pulse_q  <= 1'b1;
            end else begin
              rep_q <= rep_inc;
            end
          end
        end
      endcase
    end
  end
  assign kp.en_pulse  = en_pulse_q;
  assign kp.key_level = key_level_q;
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed and randomised checks of key_pulse_gen against edge-level expectations
module tb_key_pulse_gen;
  localparam int DEB = 4, DLY = 10, PER = 3, W = 8, N = 20000;
  logic clk = 1'b0;
  logic r = 1'b0;
  logic [1:0] cnt;
  int cyc = 0, total = 0, bad = 0;
  bit pulse_at [0:N-1];
  bit lvl_at [0:N-1];
  key_pulse_gen_if kif();
  key_pulse_gen #(.DEB_CYCLES(DEB), .REP_DELAY(DLY), .REP_PERIOD(PER), .CNT_W(W)) dut (
    .clk(clk),
    .r(r),
    .kp(kif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (cyc < N) begin
    pulse_at[cyc] = kif.en_pulse;
    lvl_at[cyc] = kif.key_level;
  end
  always @(posedge clk or posedge r) begin
    if (r) cnt <= 2'd0;
    else if (kif.en_pulse) cnt <= cnt + 2'd1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int b;
    kif.key = 1'b1;
    tick(3);
    total++;
    if (kif.en_pulse !== 1'b0) begin bad++; $display("FAIL reset_hold_pulse got=%b exp=0", kif.en_pulse); end
    total++;
    if (kif.key_level !== 1'b0) begin bad++; $display("FAIL reset_hold_level got=%b exp=0", kif.key_level); end
    r = 1'b0;
    b = cyc;
    tick(6);
    for (int e = b + 1; e <= b + 5; e++) begin
      total++;
      if (pulse_at[e] || lvl_at[e]) begin bad++; $display("FAIL reset_early off=%0d pulse=%b level=%b exp=0,0", e - b, pulse_at[e], lvl_at[e]); end
    end
    total++;
    if (kif.en_pulse !== 1'b1 || kif.key_level !== 1'b1) begin bad++; $display("FAIL reset_first_pulse pulse=%b level=%b exp=1,1", kif.en_pulse, kif.key_level); end
    #3;
    r = 1'b1;
    #1;
    total++;
    if (kif.en_pulse !== 1'b0 || kif.key_level !== 1'b0) begin bad++; $display("FAIL reset_async pulse=%b level=%b exp=0,0", kif.en_pulse, kif.key_level); end
    tick(2);
    r = 1'b0;
    b = cyc;
    tick(10);
    for (int e = b + 1; e <= b + 9; e++) begin
      total++;
      if (pulse_at[e] != (e == b + 6) || lvl_at[e] != (e >= b + 6)) begin
        bad++;
        $display("FAIL reset_midhold off=%0d pulse=%b level=%b exp=%b,%b", e - b, pulse_at[e], lvl_at[e], e == b + 6, e >= b + 6);
      end
    end
  endtask

  task automatic test_press;
    int b;
    kif.key = 1'b0;
    tick(12);
    b = cyc;
    kif.key = 1'b1;
    tick(40);
    kif.key = 1'b0;
    tick(12);
    for (int e = b + 1; e <= b + 51; e++) begin
      total++;
      if (pulse_at[e] != (e == b + 6) || lvl_at[e] != (e >= b + 6 && e <= b + 45)) begin
        bad++;
        $display("FAIL clean_press off=%0d pulse=%b level=%b exp=%b,%b", e - b, pulse_at[e], lvl_at[e], e == b + 6, e >= b + 6 && e <= b + 45);
      end
    end
  endtask

  task automatic test_bounce;
    int b;
    bit [8:0] pat;
    pat = 9'b000011011;
    b = cyc;
    for (int i = 0; i < 9; i++) begin
      kif.key = pat[i];
      tick(1);
    end
    kif.key = 1'b1;
    tick(20);
    kif.key = 1'b0;
    tick(12);
    for (int e = b + 1; e <= b + 40; e++) begin
      total++;
      if (pulse_at[e] != (e == b + 15) || lvl_at[e] != (e >= b + 15 && e <= b + 34)) begin
        bad++;
        $display("FAIL bounce off=%0d pulse=%b level=%b exp=%b,%b", e - b, pulse_at[e], lvl_at[e], e == b + 15, e >= b + 15 && e <= b + 34);
      end
    end
  endtask

  task automatic test_autorepeat;
    int b;
    bit [63:0] pm;
    pm = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25);
    kif.rep_en = 1'b1;
    b = cyc;
    kif.key = 1'b1;
    tick(26);
    kif.rep_en = 1'b0;
    tick(20);
    kif.key = 1'b0;
    tick(12);
    for (int e = b + 1; e <= b + 57; e++) begin
      total++;
      if (pulse_at[e] != pm[e - b] || lvl_at[e] != (e >= b + 6 && e <= b + 51)) begin
        bad++;
        $display("FAIL autorepeat off=%0d pulse=%b level=%b exp=%b,%b", e - b, pulse_at[e], lvl_at[e], pm[e - b], e >= b + 6 && e <= b + 51);
      end
    end
  endtask

  task automatic test_release_glitch;
    int b;
    bit [63:0] pm;
    pm = (64'd1 << 6) | (64'd1 << 18) | (64'd1 << 21) | (64'd1 << 24) | (64'd1 << 27) | (64'd1 << 30);
    kif.rep_en = 1'b1;
    b = cyc;
    kif.key = 1'b1;
    tick(12);
    kif.key = 1'b0;
    tick(2);
    kif.key = 1'b1;
    tick(16);
    kif.key = 1'b0;
    tick(12);
    for (int e = b + 1; e <= b + 41; e++) begin
      total++;
      if (pulse_at[e] != pm[e - b] || lvl_at[e] != (e >= b + 6 && e <= b + 35)) begin
        bad++;
        $display("FAIL release_glitch off=%0d pulse=%b level=%b exp=%b,%b", e - b, pulse_at[e], lvl_at[e], pm[e - b], e >= b + 6 && e <= b + 35);
      end
    end
    kif.rep_en = 1'b0;
  endtask

  task automatic test_random;
    for (int p = 0; p < 8; p++) begin
      int b, h, l, o, g, o2, g2, cnt;
      bit re;
      bit seq [0:63];
      bit ep [0:127];
      bit el [0:127];
      h = $urandom_range(45, 20);
      l = $urandom_range(DEB + 8, DEB + 3);
      re = 1'($urandom_range(1, 0));
      for (int i = 0; i < 64; i++) seq[i] = (i < h);
      if ($urandom_range(3, 0) != 0) begin
        o = $urandom_range(h - 8, DEB + 1);
        g = $urandom_range(DEB - 1, 1);
        for (int i = o; i < o + g; i++) seq[i] = 1'b0;
        o2 = o + g + $urandom_range(4, 2);
        g2 = $urandom_range(DEB - 1, 1);
        if ($urandom_range(1, 0) != 0 && o2 + g2 <= h - 2)
          for (int i = o2; i < o2 + g2; i++) seq[i] = 1'b0;
      end
      // sample seq[i] is taken at offset i+1 and seen debounced-side at offset i+3;
      // repeats fire on the DLY-th, DLY+PER-th, ... high-seen edge after the press pulse
      for (int e = 0; e < 128; e++) begin
        ep[e] = 1'b0;
        el[e] = (e >= DEB + 2) && (e <= h + 1 + DEB);
      end
      ep[DEB + 2] = 1'b1;
      cnt = 0;
      if (re)
        for (int e = DEB + 3; e <= h + 2; e++)
          if (seq[e - 3]) begin
            cnt++;
            if (cnt >= DLY && (cnt - DLY) % PER == 0) ep[e] = 1'b1;
          end
      kif.rep_en = re;
      b = cyc;
      for (int i = 0; i < h; i++) begin
        kif.key = seq[i];
        tick(1);
      end
      kif.key = 1'b0;
      tick(l + 1);
      for (int e = 1; e <= h + l; e++) begin
        total++;
        if (pulse_at[b + e] != ep[e] || lvl_at[b + e] != el[e]) begin
          bad++;
          $display("FAIL random p=%0d rep=%b off=%0d pulse=%b level=%b exp=%b,%b", p, re, e, pulse_at[b + e], lvl_at[b + e], ep[e], el[e]);
        end
      end
    end
    kif.rep_en = 1'b0;
  endtask

  task automatic test_chain;
    int b, n;
    kif.rep_en = 1'b0;
    kif.key = 1'b0;
    r = 1'b1;
    tick(1);
    r = 1'b0;
    tick(2);
    b = cyc;
    for (int i = 0; i < 5; i++) begin
      kif.key = 1'b1;
      tick(10);
      kif.key = 1'b0;
      tick(10);
    end
    n = 0;
    for (int e = b + 1; e < cyc; e++) n += int'(pulse_at[e]);
    total++;
    if (n != 5) begin bad++; $display("FAIL chain_pulses got=%0d exp=5", n); end
    total++;
    if (cnt !== 2'b01) begin bad++; $display("FAIL chain_count got=%b exp=01", cnt); end
    total++;
    if (kif.key_level !== 1'b0) begin bad++; $display("FAIL chain_level got=%b exp=0", kif.key_level); end
  endtask

  initial begin
    kif.key = 1'b0;
    kif.rep_en = 1'b0;
    #2;
    r = 1'b1;
    #1;
    total++;
    if (kif.en_pulse !== 1'b0 || kif.key_level !== 1'b0) begin bad++; $display("FAIL reset_state pulse=%b level=%b exp=0,0", kif.en_pulse, kif.key_level); end
    tick(2);
    test_reset;
    test_press;
    test_bounce;
    test_autorepeat;
    test_release_glitch;
    test_random;
    test_chain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
